// File: rtl/game_mode_ctrl.sv
// Game mode FSM: frame-aligned MENU/ARMED/PLAYING/OVER switching of the display source.
// Outputs registered (1 cycle after condition); start key edge lands 3 cycles after sampling; no backpressure.
module game_mode_ctrl #(
  parameter int HOLD_FRAMES = 120,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start_key,
  input  logic game_over,
  input  logic frame_start,
  output logic playing,
  output logic game_reset,
  output logic freeze
);

  typedef enum logic [1:0] {
    S_MENU    = 2'd0,
    S_ARMED   = 2'd1,
    S_PLAYING = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_FRAMES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             key_s1, key_s2, key_hist, start_edge;
  logic             playing_nxt, freeze_nxt, game_reset_nxt;

  // Flops reset high so a key held through reset never looks like a fresh press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1     <= 1'b1;
      key_s2     <= 1'b1;
      key_hist   <= 1'b1;
      start_edge <= 1'b0;
    end else begin
      key_s1     <= start_key;
      key_s2     <= key_s1;
      key_hist   <= key_s2;
      start_edge <= key_s2 & ~key_hist;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_MENU;
      hold_cnt   <= '0;
      playing    <= 1'b0;
      freeze     <= 1'b0;
      game_reset <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      playing    <= playing_nxt;
      freeze     <= freeze_nxt;
      game_reset <= game_reset_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    game_reset_nxt = 1'b0;
    case (state)
      S_MENU: begin
        if (start_edge) begin
          state_nxt      = S_ARMED;
          game_reset_nxt = 1'b1;
        end
      end
      S_ARMED: begin
        if (frame_start) state_nxt = S_PLAYING;
      end
      S_PLAYING: begin
        // A frame_start coinciding with game_over is not part of the hold.
        if (game_over) begin
          state_nxt    = S_OVER;
          hold_cnt_nxt = '0;
        end
      end
      S_OVER: begin
        if (frame_start) begin
          if (hold_cnt == LAST_CNT) begin
            state_nxt    = S_MENU;
            hold_cnt_nxt = '0;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt    = S_MENU;
        hold_cnt_nxt = '0;
      end
    endcase
    playing_nxt = (state_nxt == S_PLAYING) || (state_nxt == S_OVER);
    freeze_nxt  = (state_nxt == S_OVER);
  end

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Randomized plus directed bench for game_mode_ctrl against a behavioural mode model.
module tb_game_mode_ctrl;

  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_key = 1'b1;
  logic game_over = 1'b0;
  logic frame_start = 1'b0;
  logic playing, game_reset, freeze;

  int n_vec = 0;
  int n_err = 0;

  game_mode_ctrl #(.HOLD_FRAMES(HOLD), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start_key(start_key), .game_over(game_over),
    .frame_start(frame_start), .playing(playing), .game_reset(game_reset),
    .freeze(freeze)
  );

  always #5 clk = ~clk;

  // Reference: mode 0=menu 1=armed 2=playing 3=over; keys[i] = key sampled i+1 edges ago.
  int       m_mode;
  int       m_frames;
  bit       m_gr;
  bit [3:0] keys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_frames = 0; m_gr = 0; keys = 4'hF;
  endtask

  task automatic model_edge(input bit k, input bit fs, input bit go);
    bit pressed;
    pressed = keys[2] && !keys[3];
    m_gr = 0;
    case (m_mode)
      0: if (pressed) begin m_mode = 1; m_gr = 1; end
      1: if (fs) m_mode = 2;
      2: if (go) begin m_mode = 3; m_frames = 0; end
      default: if (fs) begin
        m_frames++;
        if (m_frames == HOLD) begin m_mode = 0; m_frames = 0; end
      end
    endcase
    keys = {keys[2:0], k};
  endtask

  task automatic compare_all();
    chk("playing", 32'(playing), 32'(m_mode >= 2));
    chk("freeze", 32'(freeze), 32'(m_mode == 3));
    chk("game_reset", 32'(game_reset), 32'(m_gr));
  endtask

  task automatic step(input bit k, input bit fs, input bit go);
    start_key = k; frame_start = fs; game_over = go;
    @(posedge clk);
    if (reset) model_reset(); else model_edge(k, fs, go);
    #1;
    compare_all();
  endtask

  task automatic async_reset(input int cyc);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (cyc) step(start_key, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input bit k);
    repeat (n) step(k, 1'b0, 1'b0);
  endtask

  // Press the key and wait for ARMED, then a frame_start into PLAYING.
  task automatic start_game();
    idle(4, 1'b0);
    idle(5, 1'b1);
    step(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int lat, nfs;
    bit k, fs, go, pfs, pgo;
    model_reset();

    // Key held through reset and long after: no start.
    idle(3, 1'b1);
    reset = 1'b0;
    idle(50, 1'b1);
    chk("t1_menu", 32'(playing), 32'd0);

    // Press latency and frame-aligned entry to play.
    idle(5, 1'b0);
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (game_reset && lat == 99) lat = i;
    end
    chk("t2_latency", 32'(lat), 32'd4);
    chk("t2_armed_playing", 32'(playing), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("t2_playing", 32'(playing), 32'd1);

    // Game over hold of HOLD frames.
    idle(3, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("t3_freeze", 32'(freeze), 32'd1);
    for (int f = 0; f < HOLD; f++) begin
      idle(4, 1'b1);
      step(1'b1, 1'b1, 1'b0);
    end
    chk("t3_menu_play", 32'(playing), 32'd0);
    chk("t3_menu_freeze", 32'(freeze), 32'd0);

    // Coincident game_over and frame_start do not count toward the hold.
    start_game();
    idle(2, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    nfs = 0;
    for (int f = 0; f < 10; f++) begin
      idle(3, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      nfs++;
      if (!playing) break;
    end
    chk("t4_frames", 32'(nfs), 32'(HOLD));

    // Ignored events: game_over in MENU/ARMED, key toggles in PLAYING/OVER.
    idle(3, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("t5_play_no_over", 32'(freeze), 32'd0);
    for (int t = 0; t < 3; t++) begin idle(4, 1'b0); idle(4, 1'b1); end
    step(1'b1, 1'b0, 1'b1);
    for (int t = 0; t < 3; t++) begin idle(4, 1'b0); idle(4, 1'b1); step(1'b1, 1'b0, 1'b1); end
    chk("t5_over_freeze", 32'(freeze), 32'd1);

    // Reset in OVER after two counted frames, then restart.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    async_reset(3);
    chk("t6_play", 32'(playing), 32'd0);
    chk("t6_freeze", 32'(freeze), 32'd0);
    idle(4, 1'b0);
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (game_reset && lat == 99) lat = i;
    end
    chk("t6_restart", 32'(lat), 32'd4);

    // Random traffic with occasional asynchronous resets.
    k = 1'b1; pfs = 1'b0; pgo = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 14) == 0) k = ~k;
      fs = !pfs && ($urandom_range(0, 5) == 0);
      go = !pgo && ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 599) == 0) begin
        async_reset($urandom_range(1, 3));
      end
      step(k, fs, go);
      pfs = fs; pgo = go;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
